// File: rtl/flitzip_pkg.sv
// Shared types and constants for the flit compressor.
// Holds prefix codes, widths and the per-prefix code length.
package flitzip_pkg;

  localparam int WORD_WIDTH  = 32;
  localparam int INPUT_WIDTH = 4 * WORD_WIDTH;
  localparam int CODE_BITS   = 3 + WORD_WIDTH;
  localparam int EN_BITS     = 4 * CODE_BITS;
  localparam int LEN_BITS    = 8;
  localparam int CLEN_BITS   = 6;

  localparam logic [2:0] PFX_ZERO = 3'b000;
  localparam logic [2:0] PFX_SE4  = 3'b001;
  localparam logic [2:0] PFX_SE8  = 3'b010;
  localparam logic [2:0] PFX_SE16 = 3'b011;
  localparam logic [2:0] PFX_HZ   = 3'b100;
  localparam logic [2:0] PFX_SEB2 = 3'b101;
  localparam logic [2:0] PFX_REP  = 3'b110;
  localparam logic [2:0] PFX_RAW  = 3'b111;

  function automatic logic [CLEN_BITS-1:0] code_len(
    input logic [2:0] pfx
  );
    logic [CLEN_BITS-1:0] len;
    len = 6'd35;
    unique case (pfx)
      PFX_ZERO: len = 6'd3;
      PFX_SE4:  len = 6'd7;
      PFX_SE8:  len = 6'd11;
      PFX_REP:  len = 6'd11;
      PFX_SE16: len = 6'd19;
      PFX_HZ:   len = 6'd19;
      PFX_SEB2: len = 6'd19;
      PFX_RAW:  len = 6'd35;
      default:  len = 6'd35;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/compressor_word_encoder.sv
// Frequent-pattern encoder for one 32-bit word.
// In: word. Out: left-justified 35-bit code, 6-bit length.
module word_encoder
  import flitzip_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] word,
  output logic [CODE_BITS-1:0]  code,
  output logic [CLEN_BITS-1:0]  len
);

  logic is_zero;
  logic is_se4;
  logic is_se8;
  logic is_rep;
  logic is_se16;
  logic is_hz;
  logic is_seb2;
  logic [2:0] pfx;

  // A value is sign-extended from n bits when
  // bits [31:n-1] are all equal.
  assign is_zero = (word == '0);
  assign is_se4  = &word[31:3] | ~|word[31:3];
  assign is_se8  = &word[31:7] | ~|word[31:7];
  assign is_se16 = &word[31:15] | ~|word[31:15];
  assign is_rep  = (word[31:24] == word[7:0])
                 & (word[23:16] == word[7:0])
                 & (word[15:8] == word[7:0]);
  assign is_hz   = (word[15:0] == '0);
  assign is_seb2 = (&word[31:23] | ~|word[31:23])
                 & (&word[15:7] | ~|word[15:7]);

  // Overlapping classes: first match wins.
  always_comb begin
    pfx  = PFX_RAW;
    code = {PFX_RAW, word};
    priority case (1'b1)
      is_zero: begin
        pfx  = PFX_ZERO;
        code = {PFX_ZERO, 32'b0};
      end
      is_se4: begin
        pfx  = PFX_SE4;
        code = {PFX_SE4, word[3:0], 28'b0};
      end
      is_se8: begin
        pfx  = PFX_SE8;
        code = {PFX_SE8, word[7:0], 24'b0};
      end
      is_rep: begin
        pfx  = PFX_REP;
        code = {PFX_REP, word[7:0], 24'b0};
      end
      is_se16: begin
        pfx  = PFX_SE16;
        code = {PFX_SE16, word[15:0], 16'b0};
      end
      is_hz: begin
        pfx  = PFX_HZ;
        code = {PFX_HZ, word[31:16], 16'b0};
      end
      is_seb2: begin
        pfx  = PFX_SEB2;
        code = {PFX_SEB2, word[23:16],
                word[7:0], 16'b0};
      end
      default: begin
        pfx  = PFX_RAW;
        code = {PFX_RAW, word};
      end
    endcase
  end

  assign len = code_len(pfx);

endmodule

// File: rtl/compressor.sv
// Flit compressor: four word codes packed MSB-first, 1-cycle latency.
// Ports: clk, rst, data_in, valid_in -> en_out, comp_len, valid_out.
module compressor
  import flitzip_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_WIDTH-1:0] data_in,
  input  logic                   valid_in,
  output logic [EN_BITS-1:0]     en_out,
  output logic [LEN_BITS-1:0]    comp_len,
  output logic                   valid_out
);

  logic [CODE_BITS-1:0] codes [4];
  logic [CLEN_BITS-1:0] lens  [4];
  logic [EN_BITS-1:0]   en_nxt;
  logic [LEN_BITS-1:0]  len_nxt;

  for (genvar g = 0; g < 4; g++) begin : g_enc
    word_encoder u_enc (
      .word (data_in[INPUT_WIDTH-1-g*WORD_WIDTH
                     -: WORD_WIDTH]),
      .code (codes[g]),
      .len  (lens[g])
    );
  end

  // Each code is placed at the running bit offset
  // from the top; unused code bits are already zero.
  always_comb begin
    en_nxt  = '0;
    len_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      en_nxt  = en_nxt
              | ({codes[i], {(EN_BITS-CODE_BITS){1'b0}}}
                 >> len_nxt);
      len_nxt = len_nxt + {2'b0, lens[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_out    <= '0;
      comp_len  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        en_out   <= en_nxt;
        comp_len <= len_nxt;
      end
    end
  end

endmodule

// File: tb/tb_compressor.sv
// Directed self-checking bench for compressor.
// Hand-computed codes and lengths per flit.
module tb_compressor;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] data_in;
  logic         valid_in;
  logic [139:0] en_out;
  logic [7:0]   comp_len;
  logic         valid_out;

  int n_chk  = 0;
  int n_fail = 0;

  compressor dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .en_out    (en_out),
    .comp_len  (comp_len),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [139:0] obs,
    input logic [139:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               tag, obs, exp);
    end
  endtask

  task automatic step(
    input logic [127:0] d,
    input logic         v
  );
    data_in  = d;
    valid_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(
    input string        tag,
    input logic [139:0] e_en,
    input logic [7:0]   e_len,
    input logic         e_v
  );
    chk({tag, ".v"}, 140'(valid_out), 140'(e_v));
    chk({tag, ".len"}, 140'(comp_len), 140'(e_len));
    chk({tag, ".en"}, en_out, e_en);
  endtask

  localparam logic [127:0] D1 =
    128'h0000_0000_0000_0000_FAC6_8915_ACEF_098F;
  localparam logic [139:0] E1 =
    {3'b000, 3'b000, 3'b111, 32'hFAC68915,
     3'b111, 32'hACEF098F, 64'b0};

  localparam logic [127:0] D3 =
    128'hFFFFFFFF_0000007F_12121212_ABCD0000;
  localparam logic [139:0] E3 =
    {3'b001, 4'hF, 3'b010, 8'h7F, 3'b110, 8'h12,
     3'b100, 16'hABCD, 92'b0};

  // 7+19... : 19 + 19 + 7 + 35 = 80 bits
  localparam logic [127:0] D4 =
    128'h007FFF80_FFFF8000_00000005_80000001;
  localparam logic [139:0] E4 =
    {3'b101, 16'h7F80, 3'b011, 16'h8000,
     3'b001, 4'h5, 3'b111, 32'h80000001, 60'b0};

  // Priority edges: bit3 set, negative nibble,
  // repeated byte with sign bit, half-zero.
  localparam logic [127:0] D5 =
    128'h00000008_FFFFFFF8_80808080_00010000;
  localparam logic [139:0] E5 =
    {3'b010, 8'h08, 3'b001, 4'h8, 3'b110, 8'h80,
     3'b100, 16'h0001, 92'b0};

  initial begin
    rst      = 1'b1;
    valid_in = 1'b1;
    data_in  = D1;
    step(D1, 1'b1);
    expect_out("reset", '0, 8'd0, 1'b0);

    rst = 1'b0;
    step(D1, 1'b1);
    expect_out("mixed_raw", E1, 8'd76, 1'b1);

    step('0, 1'b1);
    expect_out("all_zero", '0, 8'd12, 1'b1);

    step(D3, 1'b1);
    expect_out("se_rep_hz", E3, 8'd48, 1'b1);

    step(D4, 1'b1);
    expect_out("seb2_se16", E4, 8'd80, 1'b1);

    step(D5, 1'b1);
    expect_out("priority", E5, 8'd48, 1'b1);

    step(D1, 1'b0);
    expect_out("hold", E5, 8'd48, 1'b0);

    step(D3, 1'b1);
    expect_out("b2b_0", E3, 8'd48, 1'b1);
    step(D4, 1'b1);
    expect_out("b2b_1", E4, 8'd80, 1'b1);
    step(D1, 1'b1);
    expect_out("b2b_2", E1, 8'd76, 1'b1);
    step(D5, 1'b0);
    expect_out("b2b_hold", E1, 8'd76, 1'b0);
    step(D3, 1'b0);
    expect_out("b2b_hold2", E1, 8'd76, 1'b0);

    rst = 1'b1;
    step(D4, 1'b1);
    expect_out("reset_mid", '0, 8'd0, 1'b0);
    rst = 1'b0;
    step(D5, 1'b1);
    expect_out("post_reset", E5, 8'd48, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
